// File: rtl/ups_pkg.sv
// ups_pkg: shared widths and state encoding for the UPS ADC averager
package ups_pkg;
    localparam int DW = 12;
    localparam int MAX_LOG2 = 8;
    localparam int ACC_W = DW + MAX_LOG2;
    typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;
endpackage

// File: rtl/ups_hyst.sv
// ups_hyst: registered hysteresis comparator; set has priority over clear
module ups_hyst #(
    parameter int W = ups_pkg::DW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] value,
    input  logic         update,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    output logic         trip
);
    // set above hi, clear below lo, otherwise hold
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) trip <= 1'b0;
        else if (update) trip <= (value > hi) ? 1'b1 : (value < lo) ? 1'b0 : trip;
endmodule

// File: rtl/ups_adc_avg.sv
// ups_adc_avg: boxcar averager/decimator with hysteretic trip; UPS_ADC_AVG_MINMAX_EN adds window min/max
module ups_adc_avg #(
    parameter int MAX_LOG2 = ups_pkg::MAX_LOG2,
    parameter int DW = ups_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    cfg_log2,
    input  logic          cfg_update,
    input  logic [DW-1:0] thr_hi,
    input  logic [DW-1:0] thr_lo,
    input  logic [DW-1:0] adc,
    input  logic          adc_dv,
    output logic [DW-1:0] avg,
    output logic          avg_dv,
    output logic          trip,
    output logic [DW-1:0] win_min,
    output logic [DW-1:0] win_max
);
    import ups_pkg::*;
    localparam int AW = DW + MAX_LOG2;
    localparam int CW = MAX_LOG2 + 1;
    state_t state, state_nx;
    logic [AW-1:0] acc, sum, rnd;
    logic [CW-1:0] count, last;
    logic [3:0] l;
    logic [DW-1:0] avg_nx;
    logic live, take, go_dump;
    assign live = en && !cfg_update;
    assign take = live && adc_dv && state != IDLE;
    assign last = (CW'(1) << l) - CW'(1);
    assign go_dump = take && state == ACC && count == last;
    assign rnd = (l == 4'd0) ? '0 : AW'(1) << (l - 4'd1);
    assign sum = acc + AW'(adc) + rnd;
    assign avg_nx = DW'(sum >> l);
    assign avg_dv = state == DUMP;
    // next state: en low idles, the final sample of a window dumps, everything else accumulates
    always_comb begin
        state_nx = IDLE;
        state_nx = !en ? IDLE : go_dump ? DUMP : ACC;
    end
    // state, accumulator and counter; a sample arriving in DUMP seeds the next window
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
        end else begin
            state <= state_nx;
            acc   <= take ? (state == DUMP ? AW'(adc) : acc + AW'(adc)) : (live && state == ACC) ? acc : '0;
            count <= take ? (state == DUMP ? CW'(1) : count + CW'(1)) : (live && state == ACC) ? count : '0;
        end
    // window length latch (clamped) and rounded average captured as DUMP is entered
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            l   <= '0;
            avg <= '0;
        end else begin
            if (cfg_update) l <= (cfg_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : cfg_log2;
            if (go_dump) avg <= avg_nx;
        end
    ups_hyst #(.W(DW)) u_hyst (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (avg_nx),
        .update (go_dump),
        .hi     (thr_hi),
        .lo     (thr_lo),
        .trip   (trip)
    );
`ifdef UPS_ADC_AVG_MINMAX_EN
    logic [DW-1:0] run_min, run_max, min_nx, max_nx;
    logic first;
    assign first = state == DUMP || count == '0;
    assign min_nx = (first || adc < run_min) ? adc : run_min;
    assign max_nx = (first || adc > run_max) ? adc : run_max;
    // running extremes per window, published alongside the average
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            run_min <= '0;
            run_max <= '0;
            win_min <= '0;
            win_max <= '0;
        end else begin
            if (take) begin
                run_min <= min_nx;
                run_max <= max_nx;
            end
            if (go_dump) begin
                win_min <= min_nx;
                win_max <= max_nx;
            end
        end
`else
    assign win_min = '0;
    assign win_max = '0;
`endif
endmodule

// File: tb/tb_ups_adc_avg.sv
// tb_ups_adc_avg: directed scoreboard bench for the ADC averager
module tb_ups_adc_avg;
    logic clk = 0, rst_n = 0, en = 0, cfg_update = 0, adc_dv = 0;
    logic [3:0] cfg_log2 = 0;
    logic [11:0] thr_hi = 12'd4095, thr_lo = 12'd0, adc = 0;
    logic [11:0] avg, win_min, win_max;
    logic avg_dv, trip;
    int vectors = 0, miscompares = 0, cyc = 0;
    typedef struct {
        logic [11:0] avg;
        logic        trip;
        logic [11:0] mn;
        logic [11:0] mx;
        int          due;
    } exp_t;
    exp_t q[$];

    ups_adc_avg dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_log2(cfg_log2), .cfg_update(cfg_update),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .adc(adc), .adc_dv(adc_dv),
        .avg(avg), .avg_dv(avg_dv), .trip(trip), .win_min(win_min), .win_max(win_max)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [11:0] mm(input logic [11:0] v);
`ifdef UPS_ADC_AVG_MINMAX_EN
        return v;
`else
        return 12'd0 & v;
`endif
    endfunction

    // monitor: every avg_dv pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && avg_dv) begin
            if (q.size() == 0) begin
                check("unexpected_avg_dv", 32'(avg), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("avg", 32'(avg), 32'(e.avg));
                check("trip", 32'(trip), 32'(e.trip));
                check("win_min", 32'(win_min), 32'(e.mn));
                check("win_max", 32'(win_max), 32'(e.mx));
                check("latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic cfg(input logic [3:0] lg);
        @(posedge clk); #1;
        cfg_log2 = lg; cfg_update = 1;
        @(posedge clk); #1;
        cfg_update = 0;
    endtask

    task automatic sample(input logic [11:0] v, input bit last, input logic [11:0] ea, input bit et,
                          input logic [11:0] emn, input logic [11:0] emx);
        @(posedge clk); #1;
        adc = v; adc_dv = 1;
        if (last) q.push_back('{ea, et, mm(emn), mm(emx), cyc + 1});
        @(posedge clk); #1;
        adc_dv = 0;
    endtask

    task automatic s1(input logic [11:0] v, input bit et);
        sample(v, 1, v, et, v, v);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        check("drain_pending", 32'(q.size()), 0);
        q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_avg", 32'(avg), 0);
        check("rst_avg_dv", 32'(avg_dv), 0);
        check("rst_trip", 32'(trip), 0);
        check("rst_min", 32'(win_min), 0);
        check("rst_max", 32'(win_max), 0);
        rst_n = 1; en = 1;
        // L=2 rounding
        cfg(2);
        sample(100, 0, 0, 0, 0, 0);
        sample(101, 0, 0, 0, 0, 0);
        sample(102, 0, 0, 0, 0, 0);
        sample(104, 1, 102, 0, 100, 104);
        drain();
        // L=0 pass-through extremes
        cfg(0);
        s1(4095, 0);
        s1(0, 0);
        drain();
        // hysteresis
        thr_hi = 2000; thr_lo = 1000;
        s1(1500, 0);
        s1(2001, 1);
        s1(1500, 1);
        s1(999, 0);
        thr_hi = 500; thr_lo = 3000;
        s1(1000, 1);
        s1(400, 0);
        drain();
        thr_hi = 4095; thr_lo = 0;
        // cfg_update mid-window drops the coincident sample
        cfg(3);
        for (int i = 0; i < 5; i++) sample(50, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        cfg_log2 = 2; cfg_update = 1; adc = 999; adc_dv = 1;
        @(posedge clk); #1;
        cfg_update = 0; adc_dv = 0;
        sample(10, 0, 0, 0, 0, 0);
        sample(20, 0, 0, 0, 0, 0);
        sample(30, 0, 0, 0, 0, 0);
        sample(40, 1, 25, 0, 10, 40);
        drain();
        // clamp to 256 samples, full scale
        thr_hi = 4000; thr_lo = 0;
        cfg(15);
        for (int i = 0; i < 255; i++) sample(4095, 0, 0, 0, 0, 0);
        sample(4095, 1, 4095, 1, 4095, 4095);
        drain();
        // en drop mid-window discards it and holds outputs
        for (int i = 0; i < 3; i++) sample(1, 0, 0, 0, 0, 0);
        en = 0;
        repeat (20) @(posedge clk);
        #1;
        check("hold_avg", 32'(avg), 4095);
        check("hold_trip", 32'(trip), 1);
        check("idle_avg_dv", 32'(avg_dv), 0);
        // asynchronous reset mid-cycle
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("async_avg", 32'(avg), 0);
        check("async_trip", 32'(trip), 0);
        check("async_min", 32'(win_min), 0);
        check("async_max", 32'(win_max), 0);
        @(posedge clk); #1;
        rst_n = 1; en = 1;
        // window min/max
        cfg(2);
        sample(7, 0, 0, 0, 0, 0);
        sample(3, 0, 0, 0, 0, 0);
        sample(9, 0, 0, 0, 0, 0);
        sample(5, 1, 6, 0, 3, 9);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ups_adc_avg.md
Name: ups_adc_avg

Overview:
- Boxcar averager/decimator between the ADC SPI reader and the UPS control block.
- Consumes 12-bit ADC samples with a one-cycle data-valid pulse.
- Accumulates 2^L samples and emits one rounded 12-bit average per window as a data-valid pulse.
- Drives a hysteretic over-threshold trip flag, evaluated on each new average; window length and thresholds come from AXI-lite registers.

Parameters:
- MAX_LOG2, 8, largest supported log2 of the window length; accumulator width is 12+MAX_LOG2.
- DW, 12, ADC sample width.

Ports:
- clk  input  1  system clock (fabric clock).
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  block enable, level.
- cfg_log2  input  4  requested log2 window length, sampled on cfg_update.
- cfg_update  input  1  one-cycle pulse: latch cfg_log2 and restart the window.
- thr_hi  input  DW  trip set threshold.
- thr_lo  input  DW  trip clear threshold.
- adc  input  DW  ADC sample.
- adc_dv  input  1  one-cycle sample valid.
- avg  output  DW  window average, held between updates.
- avg_dv  output  1  one-cycle pulse: avg updated.
- trip  output  1  hysteretic over-threshold flag.
- win_min  output  DW  window minimum (optional feature).
- win_max  output  DW  window maximum (optional feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; acc, count, avg, win_min, win_max = 0.
  - avg_dv=0, trip=0.
  - L (latched log2) = 0.
- Config latch: L = min(cfg_log2, MAX_LOG2), latched on cfg_update. cfg_update also clears acc and count.
- States:
  - IDLE: acc and count held at 0; adc_dv ignored. en=1 -> ACC.
  - ACC: on adc_dv, acc += adc and count += 1. When adc_dv arrives with count == 2^L-1 -> DUMP, with acc holding the full sum.
  - DUMP (one cycle): avg <= (acc + (L>0 ? 2^(L-1) : 0)) >> L; avg_dv=1 this cycle; acc and count cleared. An adc_dv in this cycle seeds the new window: acc=adc, count=1. Next state is ACC.
- Latency: avg_dv rises exactly 1 cycle after the adc_dv of the last sample in the window.
- Window length 1 (L=0): every sample passes through, avg=adc, one cycle late.
- No saturation is needed: the rounded sum always fits in DW+L bits, and the maximum average is 4095.
- Trip rule, evaluated in the same cycle as the avg update, using the new average:
  - new avg > thr_hi -> trip=1.
  - else new avg < thr_lo -> trip=0.
  - else trip holds.
  - If thr_lo > thr_hi, the set condition has priority.
- en deasserted in any state:
  - next cycle the block is in IDLE with acc and count cleared; a partial window is discarded.
  - avg and trip hold their values.
  - If en falls during DUMP, the DUMP output still completes.
- cfg_update in any state:
  - restarts the window at count=0 and discards the partial sum.
  - cfg_update with adc_dv in the same cycle: the sample is discarded.
  - cfg_update during DUMP: that avg_dv still fires; the new window then starts empty.
  - State goes to ACC if en=1, else IDLE.
- count width is MAX_LOG2+1 bits, so it never wraps within a window.
- adc_dv pulses are assumed at least 2 cycles apart (ADC rate); back-to-back pulses are still accumulated correctly.

Optional Feature:
- Macro UPS_ADC_AVG_MINMAX_EN.
- Defined:
  - running min and max registers track each window; first sample loads both.
  - win_min and win_max update together with avg in DUMP.
  - The running registers are discarded on en low or cfg_update.
- Undefined: the min/max logic is removed; win_min and win_max are tied to 0.

Decomposition:
- Package ups_pkg: DW, MAX_LOG2, state enum (IDLE, ACC, DUMP), and a localparam for the accumulator width.
- One sub-module, ups_hyst: a registered hysteresis comparator with inputs value, update, hi, lo and output trip. It is reusable for later current/voltage limits.

Test Plan:
- L=2, samples 100, 101, 102, 104 -> avg_dv 1 cycle after the 4th sample; avg = (407+2)>>2 = 102.
- L=0, samples 4095 then 0 -> two avg_dv pulses: avg=4095, then avg=0.
- thr_hi=2000, thr_lo=1000, successive averages 1500, 2001, 1500, 999 -> trip 0, 1, 1, 0.
- L=3; cfg_update (cfg_log2=2) after 5 samples with the same cycle's adc_dv -> that sample is dropped; next avg_dv only after 4 further samples.
- cfg_log2=15 -> L clamps to 8; avg_dv after 256 samples of 4095 gives avg=4095. Then drop en mid-window -> no avg_dv; avg and trip hold; asserting rst_n=0 asynchronously clears all outputs.
- With UPS_ADC_AVG_MINMAX_EN defined, L=2, samples 7, 3, 9, 5 -> win_min=3, win_max=9, avg=6. Without the macro both read 0.
